// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam int HDR_BYTES = 4;
    localparam int LEN_WIDTH = 32;

endpackage

// File: rtl/instr_mem_loader.sv
// Boot-time stream-to-instruction-memory writer: length header, then payload bytes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// HDR     | collecting the 4-byte big-endian length
// PAYLOAD | writing payload bytes to consecutive addresses
// CHECK   | waiting for the checksum byte (checksum build only)
// DONE    | load complete, CPU released
// ERROR   | bad length or checksum, CPU stays held
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 8,
    parameter int          MEM_BYTES     = 64,
    parameter int unsigned BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cpu_hold
);

    localparam int HC_W = $clog2(HDR_BYTES);

    state_e                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [HC_W-1:0]          hdr_cnt_q, hdr_cnt_d;
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]     len_shift;
    logic                     xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    csum_q, csum_d;
`endif

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        len_d       = len_q;
        hdr_cnt_d   = hdr_cnt_q;
        cnt_d       = cnt_q;
        len_shift   = {len_q[LEN_WIDTH-DATA_WIDTH-1:0], in_data};
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d   = HDR;
                    hdr_cnt_d = '0;
                    len_d     = '0;
                    cnt_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
                    len_d     = len_shift;
                    hdr_cnt_d = hdr_cnt_q + HC_W'(1);
                    if (hdr_cnt_q == HC_W'(HDR_BYTES - 1)) begin
                        cnt_d = '0;
                        if (len_shift == '0) begin
                            state_d = DONE;
                        end else if (len_shift > LEN_WIDTH'(MEM_BYTES)) begin
                            state_d = ERROR;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'(cnt_q);
                    mem_wdata_d = in_data;
                    cnt_d       = cnt_q + LEN_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ in_data;
                    if (cnt_q == len_q - LEN_WIDTH'(1)) state_d = CHECK;
`else
                    if (cnt_q == len_q - LEN_WIDTH'(1)) state_d = DONE;
`endif
                end
            end
            CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) state_d = (in_data == csum_q) ? DONE : ERROR;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // in_ready is registered, so it is derived from the state being entered.
        in_ready_d = (state_d == HDR) || (state_d == PAYLOAD) || (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            len_q       <= '0;
            hdr_cnt_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            len_q       <= len_d;
            hdr_cnt_q   <= hdr_cnt_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end
`endif

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == HDR) || (state_q == PAYLOAD) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    // Decoded from the async-reset state so the hold asserts the moment rst_n drops.
    assign cpu_hold  = (state_q != DONE);

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Boot-time writer for the byte-addressed instruction memory. It accepts a byte stream over a valid/ready handshake: a 4-byte big-endian length header, then the payload bytes. Each payload byte is written to consecutive instruction-memory byte addresses, so the fetch side's big-endian word read {A, A+1, A+2, A+3} sees words in stream order. The CPU is held in reset via cpu_hold until a load completes.

Parameters:
ADDRESS_WIDTH, 32, width of mem_addr (matches fetch address width)
DATA_WIDTH, 8, byte width of stream and memory write data
MEM_BYTES, 64, instruction memory depth in bytes; largest legal length
BASE_ADDR, 0, byte address of the first payload byte

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
in_valid  input  1  stream byte valid
in_data  input  DATA_WIDTH  stream byte
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction-memory byte write enable
mem_addr  output  ADDRESS_WIDTH  write byte address
mem_wdata  output  DATA_WIDTH  write byte
busy  output  1  high in HDR, PAYLOAD and CHECK
done  output  1  high in DONE
error  output  1  high in ERROR; sticky until start or reset
cpu_hold  output  1  holds the CPU in reset; low only in DONE

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n low forces IDLE immediately.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1. Length register and counters clear to 0.
- Handshake: a byte transfers on a rising edge with in_valid&&in_ready. in_ready is a registered function of state: 1 in HDR, PAYLOAD and CHECK, else 0. in_data is ignored when no transfer occurs.
- IDLE: start -> HDR.
- DONE / ERROR: start -> HDR. Entering HDR clears done, error and the header count.
- start in HDR, PAYLOAD or CHECK is ignored.
- HDR:
  - Accept 4 bytes MSB-first into len[31:0].
  - On the 4th byte: len==0 -> DONE; len>MEM_BYTES -> ERROR; else -> PAYLOAD with cnt=0.
- PAYLOAD:
  - Byte k is written as mem_we=1, mem_addr=BASE_ADDR+k, mem_wdata=byte. The write is registered and appears exactly 1 cycle after the transfer edge.
  - mem_we is high for one cycle per accepted byte and never without a transfer.
  - Back-to-back transfers give back-to-back writes.
  - After byte len-1 -> DONE, or -> CHECK when the optional feature is enabled.
- Address arithmetic is ADDRESS_WIDTH-bit unsigned. Wrap cannot occur because len<=MEM_BYTES is checked first.
- DONE: done=1, cpu_hold=0, busy=0. The state is held until start.
- ERROR: error=1, cpu_hold=1. No further writes occur.
- Reset mid-load: return to IDLE with cpu_hold=1. Memory contents already written are left untouched (undefined program). cpu_hold rises asynchronously with rst_n low.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - A running XOR of all payload bytes is kept and cleared on entry to HDR.
  - After the last payload byte the state goes to CHECK, which accepts exactly one byte.
  - If that byte equals the XOR -> DONE, else -> ERROR.
  - The checksum byte is never written to memory.
- Undefined: no CHECK state and no XOR logic; the stream ends at the last payload byte.

Decomposition:
- Package loader_pkg holds:
  - state enum {IDLE, HDR, PAYLOAD, CHECK, DONE, ERROR} (CHECK is present but unreachable when the feature is off);
  - HDR_BYTES=4;
  - LEN_WIDTH=32.
- Single module, no sub-module. The header shift register, payload counter and checksum are small enough to inline.

Test Plan:
- Reset, then IDLE: cpu_hold=1, in_ready=0, done=0; in_valid=1 with no start -> no mem_we.
- Nominal load: start; stream 00 00 00 08, then 13 05 A0 00 93 05 10 00 -> 8 writes at addresses 0..7 with those bytes, each 1 cycle after its transfer; then done=1, cpu_hold=0.
- Backpressure gaps: same stream with in_valid toggling every other cycle -> identical writes, mem_we only after transfers.
- Length checks:
  - header 00 00 00 41 (65>64) -> error=1, cpu_hold=1, zero writes;
  - header 00 00 00 00 -> DONE with zero writes.
- Reset mid-load: assert rst_n=0 after the 3rd payload byte -> immediate IDLE, cpu_hold=1. A fresh start plus a full stream then reloads correctly.
- With LOADER_CHECKSUM_EN:
  - payload 01 02 03 04 + checksum 04 -> done;
  - checksum 05 -> error=1; a new start clears error and the reload succeeds.
